mul_unit: RTL and testbench

Iterative multi-cycle integer multiplier functional unit on issue port 2, the MUL port. It consumes one issued RV64M multiply per operation, along with the operands read from the physical register file. It produces a 64-bit result tagged with the destination physical register. It also raises `muti_finish`, which the issue-stage arbiter and wake-up logic use to release and wake dependants of the in-flight multiply.

---
 rtl/rv64_pkg.sv | 11 +
 rtl/mul_step.sv | 15 +
 rtl/mul_unit.sv | 111 +++++++++++
 tb/tb_mul_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// rv64_pkg: RV64M multiply opcode/func3 encodings, unit state type and the default register tag width.
package rv64_pkg;
   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam int PRF_WIDTH = 6;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mul_state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add iteration that retires STEP multiplier bits from the low half of the accumulator.
module mul_step #(
   parameter int DATA_WIDTH = 64,
   parameter int STEP       = 2
) (
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   mcand,
   output logic [2*DATA_WIDTH-1:0] acc_next
);
   logic [DATA_WIDTH+STEP-1:0] sum;
   // Product bits enter at the top of the low half and slide down as multiplier bits are consumed.
   assign sum = (DATA_WIDTH+STEP)'(acc[2*DATA_WIDTH-1:DATA_WIDTH])
              + (DATA_WIDTH+STEP)'(mcand) * (DATA_WIDTH+STEP)'(acc[STEP-1:0]);
   assign acc_next = {sum, acc[DATA_WIDTH-1:STEP]};
endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative RV64M multiplier on the MUL issue port.
// MUL_EARLY_WAKEUP_EN moves the muti_finish pulse from DONE to FIX.
module mul_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int PRF_WIDTH  = rv64_pkg::PRF_WIDTH,
   parameter int MUL_STEP   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_op,
   input  logic [2:0]            in_func3,
   input  logic [PRF_WIDTH-1:0]  in_prd,
   input  logic                  in_prd_v,
   input  logic [DATA_WIDTH-1:0] in_src1,
   input  logic [DATA_WIDTH-1:0] in_src2,
   output logic                  busy,
   output logic                  muti_finish,
   output logic                  wb_valid,
   output logic [PRF_WIDTH-1:0]  wb_prd,
   output logic                  wb_prd_v,
   output logic [DATA_WIDTH-1:0] wb_data
);
   import rv64_pkg::*;
   localparam int N_FULL = DATA_WIDTH / MUL_STEP;
   localparam int N_WORD = 32 / MUL_STEP;
   localparam int CW     = $clog2(N_FULL + 1);
   mul_state_t state, state_next;
   logic [2*DATA_WIDTH-1:0] acc, acc_step, prod, fixed;
   logic [DATA_WIDTH-1:0] mcand, a_ext, b_ext, a_mag, b_mag, res;
   logic [CW-1:0] cnt;
   logic [PRF_WIDTH-1:0] prd_q;
   logic prd_v_q, word_q, hi_q, zero_q, neg_q;
   logic word, sign_a, sign_b;
   assign word   = in_op == OP_32;
   assign a_ext  = word ? DATA_WIDTH'($signed(in_src1[31:0])) : in_src1;
   assign b_ext  = word ? DATA_WIDTH'($signed(in_src2[31:0])) : in_src2;
   // rs1 is signed for everything but MULHU; rs2 only for MUL/MULH (and all word ops).
   assign sign_a = a_ext[DATA_WIDTH-1] & (word | (in_func3[1:0] != F3_MULHU[1:0]));
   assign sign_b = b_ext[DATA_WIDTH-1] & (word | (in_func3[1:0] == F3_MUL[1:0]) | (in_func3[1:0] == F3_MULH[1:0]));
   assign a_mag  = sign_a ? -a_ext : a_ext;
   assign b_mag  = sign_b ? -b_ext : b_ext;
   mul_step #(.DATA_WIDTH(DATA_WIDTH), .STEP(MUL_STEP)) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .acc_next (acc_step)
   );
   // Word ops stop after 32 shifts, leaving the product 32 bits up the accumulator.
   assign prod  = word_q ? acc >> 32 : acc;
   assign fixed = neg_q ? -prod : prod;
   assign res   = zero_q ? '0 : word_q ? DATA_WIDTH'($signed(fixed[31:0])) :
                  hi_q ? fixed[2*DATA_WIDTH-1:DATA_WIDTH] : fixed[DATA_WIDTH-1:0];
   always_comb begin
      state_next  = state;
      in_ready    = state == IDLE;
      busy        = state != IDLE;
`ifdef MUL_EARLY_WAKEUP_EN
      muti_finish = state == FIX;
`else
      muti_finish = state == DONE;
`endif
      case (state)
         IDLE:    state_next = in_valid ? CALC : IDLE;
         CALC:    state_next = cnt == CW'(1) ? FIX : CALC;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         mcand    <= '0;
         cnt      <= '0;
         prd_q    <= '0;
         prd_v_q  <= 1'b0;
         word_q   <= 1'b0;
         hi_q     <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         wb_valid <= 1'b0;
         wb_prd   <= '0;
         wb_prd_v <= 1'b0;
         wb_data  <= '0;
      end else begin
         state    <= state_next;
         wb_valid <= state == FIX;
         if (state == IDLE && in_valid) begin
            acc     <= {{DATA_WIDTH{1'b0}}, b_mag};
            mcand   <= a_mag;
            cnt     <= word ? CW'(N_WORD) : CW'(N_FULL);
            prd_q   <= in_prd;
            prd_v_q <= in_prd_v;
            word_q  <= word;
            hi_q    <= !word & (in_func3[1:0] != F3_MUL[1:0]);
            zero_q  <= !word & in_func3[2];
            neg_q   <= sign_a ^ sign_b;
         end
         if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt - CW'(1);
         end
         if (state == FIX) begin
            wb_data  <= res;
            wb_prd   <= prd_q;
            wb_prd_v <= prd_v_q;
         end
      end
   end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and randomized checks of mul_unit against a wide-arithmetic reference model.
module tb_mul_unit;
   localparam logic [6:0] OPC = 7'b0110011;
   localparam logic [6:0] OPW = 7'b0111011;
   logic clk = 0, rst = 1, in_valid = 0, in_prd_v = 0;
   logic in_ready, busy, muti_finish, wb_valid, wb_prd_v;
   logic [6:0] in_op = OPC;
   logic [2:0] in_func3 = 0;
   logic [5:0] in_prd = 0, wb_prd;
   logic [63:0] in_src1 = 0, in_src2 = 0, wb_data;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   mul_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_func3(in_func3), .in_prd(in_prd), .in_prd_v(in_prd_v), .in_src1(in_src1),
      .in_src2(in_src2), .busy(busy), .muti_finish(muti_finish), .wb_valid(wb_valid),
      .wb_prd(wb_prd), .wb_prd_v(wb_prd_v), .wb_data(wb_data)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] ref_mul(input bit word, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] sa, sb, ua, ub, p;
      logic [63:0] w;
      if (word) begin
         w = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]};
         return {{32{w[31]}}, w[31:0]};
      end
      if (f3[2]) return 64'd0;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      ua = {64'd0, a};
      ub = {64'd0, b};
      p = (f3[1:0] == 2'd0 || f3[1:0] == 2'd1) ? sa * sb : (f3[1:0] == 2'd2) ? sa * ub : ua * ub;
      return f3[1:0] == 2'd0 ? p[63:0] : p[127:64];
   endfunction
   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'h8000_0000_0000_0000;
         2:       return '1;
         3:       return 64'hFFFF_FFFF_8000_0000;
         4:       return 64'(int'($urandom_range(0, 9)) - 5);
         default: return {$urandom, $urandom};
      endcase
   endfunction
   task automatic run_op(input bit word, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] prd, input bit prd_v, input logic [63:0] exp, input bit hold);
      int n, k, mf_k, mf_exp;
      bit rdy_bad;
      n = word ? 16 : 32;
`ifdef MUL_EARLY_WAKEUP_EN
      mf_exp = n;
`else
      mf_exp = n + 1;
`endif
      @(negedge clk);
      in_valid = 1;
      in_op = word ? OPW : OPC;
      in_func3 = f3;
      in_src1 = a;
      in_src2 = b;
      in_prd = prd;
      in_prd_v = prd_v;
      @(posedge clk);
      #1;
      check("accept_busy", 64'(busy), 64'd1);
      if (!hold) in_valid = 0;
      k = 0;
      mf_k = -1;
      rdy_bad = 0;
      while (!wb_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
         if (muti_finish && mf_k < 0) mf_k = k;
         if (in_ready) rdy_bad = 1;
      end
      check("latency", 64'(k), 64'(n + 1));
      check("wb_data", wb_data, exp);
      check("wb_prd", 64'(wb_prd), 64'(prd));
      check("wb_prd_v", 64'(wb_prd_v), 64'(prd_v));
      check("finish_cycle", 64'(mf_k), 64'(mf_exp));
      check("ready_low", 64'(rdy_bad), 64'd0);
      @(posedge clk);
      #1;
      check("wb_pulse", 64'(wb_valid), 64'd0);
      check("wb_hold", wb_data, exp);
      check("ready_back", 64'(in_ready), 64'd1);
   endtask
   initial begin
      bit word, seen;
      logic [2:0] f3;
      logic [63:0] a, b;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_finish", 64'(muti_finish), 64'd0);
      check("rst_wb", {wb_data[61:0], wb_valid, wb_prd_v}, 64'd0);
      check("rst_prd", 64'(wb_prd), 64'd0);
      @(negedge clk);
      rst = 0;
      run_op(0, 3'b000, 64'd7, -64'sd3, 6'd13, 1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      run_op(0, 3'b001, '1, '1, 6'd1, 1, 64'h0, 0);
      run_op(0, 3'b011, '1, '1, 6'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op(0, 3'b010, '1, '1, 6'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(1, 3'b000, 64'h0000_0001_0001_0000, 64'h1_0000, 6'd4, 1, 64'h0, 0);
      run_op(1, 3'b000, 64'h7FFF_FFFF, 64'd2, 6'd5, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op(0, 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd6, 1, 64'h4000_0000_0000_0000, 0);
      run_op(0, 3'b101, 64'd9, 64'd9, 6'd7, 1, 64'h0, 0);
      run_op(0, 3'b000, 64'd5, 64'd6, 6'd8, 1, 64'd30, 1);
      run_op(0, 3'b000, 64'd5, 64'd6, 6'd8, 1, 64'd30, 0);
      @(negedge clk);
      in_valid = 1;
      in_op = OPC;
      in_func3 = 3'b000;
      in_src1 = 64'd11;
      in_src2 = 64'd11;
      in_prd = 6'd9;
      in_prd_v = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1;
      #1;
      check("abort_ready", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_wb", {wb_data[61:0], wb_valid, wb_prd_v}, 64'd0);
      check("abort_prd", 64'(wb_prd), 64'd0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (wb_valid || muti_finish) seen = 1;
      end
      check("abort_silent", 64'(seen), 64'd0);
      run_op(0, 3'b000, 64'd12, 64'd12, 6'd10, 1, 64'd144, 0);
      for (int i = 0; i < 40; i++) begin
         word = 1'($urandom_range(0, 1));
         f3 = word ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         run_op(word, f3, a, b, 6'($urandom), 1'($urandom), ref_mul(word, f3, a, b), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
